// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS register file and its read ports.
package mips_pkg;

    localparam int DATA_WIDTH = 32'sd32;
    localparam int ADDR_WIDTH = 32'sd5;
    localparam int REG_COUNT  = int'(32'd1 << ADDR_WIDTH);

    typedef logic [ADDR_WIDTH-1:0] reg_idx_t;
    typedef logic [DATA_WIDTH-1:0] reg_word_t;

    localparam reg_idx_t ZERO_REG = {ADDR_WIDTH{1'b0}};

endpackage

// File: rtl/reg_read_port.sv
// Combinational register read with write-through bypass; index 0 always reads as zero.
module reg_read_port
    import mips_pkg::*;
(
    input  reg_word_t regs [REG_COUNT],
    input  reg_idx_t  addr,
    input  logic      wr_en,
    input  reg_idx_t  wr_addr,
    input  reg_word_t wr_data,
    output reg_word_t rd_data
);

    reg_word_t rd_data_s;

    // Zero register first, then an in-flight write, then stored contents.
    always_comb begin
        rd_data_s = {DATA_WIDTH{1'b0}};
        if (addr == ZERO_REG) begin
            rd_data_s = {DATA_WIDTH{1'b0}};
        end else if (wr_en && (wr_addr == addr)) begin
            rd_data_s = wr_data;
        end else begin
            rd_data_s = regs[addr];
        end
    end

    assign rd_data = rd_data_s;

endmodule

// File: rtl/reg_bank.sv
// MIPS 32x32 general-purpose register file: two combinational operand ports
// and a registered request/valid debug port, all sharing the same bypass rule.
module reg_bank
    import mips_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [ADDR_WIDTH-1:0] i_rs_addr,
    input  logic [ADDR_WIDTH-1:0] i_rt_addr,
    output logic [DATA_WIDTH-1:0] o_rs_data,
    output logic [DATA_WIDTH-1:0] o_rt_data,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_dbg_req,
    input  logic [ADDR_WIDTH-1:0] i_dbg_addr,
    output logic [DATA_WIDTH-1:0] o_dbg_data,
    output logic                  o_dbg_valid
);

    reg_word_t regs_r [REG_COUNT];
    reg_word_t dbg_rd_s;
    reg_word_t dbg_data_r;
    logic      dbg_valid_r;

    // Register storage; entry 0 is kept at zero so it never holds stale data.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            regs_r[0] <= {DATA_WIDTH{1'b0}};
            for (int i = 1; i < REG_COUNT; i++) begin
                if (i_wr_en && (i_wr_addr == reg_idx_t'(i))) begin
                    regs_r[i] <= i_wr_data;
                end
            end
        end
    end

    reg_read_port u_rs_port (
        .regs    (regs_r),
        .addr    (i_rs_addr),
        .wr_en   (i_wr_en),
        .wr_addr (i_wr_addr),
        .wr_data (i_wr_data),
        .rd_data (o_rs_data)
    );

    reg_read_port u_rt_port (
        .regs    (regs_r),
        .addr    (i_rt_addr),
        .wr_en   (i_wr_en),
        .wr_addr (i_wr_addr),
        .wr_data (i_wr_data),
        .rd_data (o_rt_data)
    );

    // The bypass makes the captured value equal to the post-edge register contents.
    reg_read_port u_dbg_port (
        .regs    (regs_r),
        .addr    (i_dbg_addr),
        .wr_en   (i_wr_en),
        .wr_addr (i_wr_addr),
        .wr_data (i_wr_data),
        .rd_data (dbg_rd_s)
    );

    // Debug response register: one valid cycle per accepted request, data holds otherwise.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            dbg_valid_r <= 1'b0;
            dbg_data_r  <= {DATA_WIDTH{1'b0}};
        end else if (i_dbg_req) begin
            dbg_valid_r <= 1'b1;
            dbg_data_r  <= dbg_rd_s;
        end else begin
            dbg_valid_r <= 1'b0;
        end
    end

    assign o_dbg_data  = dbg_data_r;
    assign o_dbg_valid = dbg_valid_r;

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: operand-read vector table, reference model
// and a queue of expected debug responses.
module tb_reg_bank;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [4:0]  i_rs_addr, i_rt_addr, i_wr_addr, i_dbg_addr;
    logic [31:0] o_rs_data, o_rt_data, i_wr_data, o_dbg_data;
    logic        i_wr_en, i_dbg_req, o_dbg_valid;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [32];
    logic [31:0] exp_q [$];
    logic        exp_valid;
    logic [31:0] last_dbg;

    typedef struct {
        logic        wr_en;
        logic [4:0]  wr_addr;
        logic [31:0] wr_data;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] exp_rs;
        logic [31:0] exp_rt;
    } vec_t;

    vec_t vecs [$];

    reg_bank dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_rs_addr   (i_rs_addr),
        .i_rt_addr   (i_rt_addr),
        .o_rs_data   (o_rs_data),
        .o_rt_data   (o_rt_data),
        .i_wr_en     (i_wr_en),
        .i_wr_addr   (i_wr_addr),
        .i_wr_data   (i_wr_data),
        .i_dbg_req   (i_dbg_req),
        .i_dbg_addr  (i_dbg_addr),
        .o_dbg_data  (o_dbg_data),
        .o_dbg_valid (o_dbg_valid)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (i_wr_en && i_wr_addr == a) return i_wr_data;
        return model[a];
    endfunction

    // One clock edge: update the model, queue any debug response, then check the debug port.
    task automatic tick();
        if (!i_reset) begin
            for (int k = 0; k < 32; k++) model[k] = 32'd0;
            exp_q.delete();
            exp_valid = 1'b0;
            last_dbg  = 32'd0;
        end else begin
            if (i_dbg_req) begin
                exp_q.push_back(ref_read(i_dbg_addr));
                exp_valid = 1'b1;
            end else begin
                exp_valid = 1'b0;
            end
            if (i_wr_en && i_wr_addr != 5'd0) model[i_wr_addr] = i_wr_data;
        end
        @(posedge i_clk);
        #1;
        check("dbg_valid", {31'd0, o_dbg_valid}, {31'd0, exp_valid});
        if (exp_valid && exp_q.size() > 0) last_dbg = exp_q.pop_front();
        check("dbg_data", o_dbg_data, last_dbg);
    endtask

    task automatic set_wr(input logic en, input logic [4:0] a, input logic [31:0] d);
        i_wr_en = en; i_wr_addr = a; i_wr_data = d;
    endtask

    initial begin
        for (int k = 0; k < 32; k++) model[k] = 32'd0;
        exp_valid = 1'b0; last_dbg = 32'd0;
        i_reset = 1'b0; i_rs_addr = 5'd0; i_rt_addr = 5'd0;
        set_wr(1'b0, 5'd0, 32'd0);
        i_dbg_req = 1'b0; i_dbg_addr = 5'd0;
        tick();
        tick();
        check("reset_rs", o_rs_data, 32'd0);

        // Reset clears storage
        i_reset = 1'b1;
        set_wr(1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        set_wr(1'b0, 5'd0, 32'd0);
        i_rs_addr = 5'd5;
        #1 check("pre_reset_r5", o_rs_data, 32'hDEADBEEF);
        i_reset = 1'b0;
        tick();
        i_reset = 1'b1;
        #1 check("post_reset_r5", o_rs_data, 32'd0);

        // Operand-read vector table: expectations are the pre-edge values
        vecs.push_back('{1'b1, 5'd3,  32'd3,        5'd0,  5'd0,  32'd0,        32'd0});
        vecs.push_back('{1'b1, 5'd4,  32'd4,        5'd3,  5'd3,  32'd3,        32'd3});
        vecs.push_back('{1'b1, 5'd5,  32'd5,        5'd4,  5'd3,  32'd4,        32'd3});
        vecs.push_back('{1'b1, 5'd6,  32'd6,        5'd5,  5'd6,  32'd5,        32'd6});
        vecs.push_back('{1'b0, 5'd0,  32'd0,        5'd3,  5'd6,  32'd3,        32'd6});
        vecs.push_back('{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd0,  32'd0,        32'd0});
        vecs.push_back('{1'b0, 5'd0,  32'd0,        5'd0,  5'd0,  32'd0,        32'd0});
        vecs.push_back('{1'b1, 5'd7,  32'h11,       5'd7,  5'd0,  32'h11,       32'd0});
        vecs.push_back('{1'b1, 5'd7,  32'h22,       5'd7,  5'd7,  32'h22,       32'h22});
        vecs.push_back('{1'b0, 5'd7,  32'h99,       5'd7,  5'd7,  32'h22,       32'h22});
        vecs.push_back('{1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd30, 32'hFFFFFFFF, 32'd0});
        vecs.push_back('{1'b0, 5'd0,  32'd0,        5'd31, 5'd5,  32'hFFFFFFFF, 32'd5});
        foreach (vecs[n]) begin
            set_wr(vecs[n].wr_en, vecs[n].wr_addr, vecs[n].wr_data);
            i_rs_addr = vecs[n].rs;
            i_rt_addr = vecs[n].rt;
            #1;
            check($sformatf("vec%0d_rs", n), o_rs_data, vecs[n].exp_rs);
            check($sformatf("vec%0d_rt", n), o_rt_data, vecs[n].exp_rt);
            tick();
        end

        // Address changes alone, no clock edge
        i_rs_addr = 5'd3; i_rt_addr = 5'd6;
        #1 check("comb_rs3", o_rs_data, 32'd3);
        check("comb_rt6", o_rt_data, 32'd6);
        i_rs_addr = 5'd4;
        #1 check("comb_rs4", o_rs_data, 32'd4);
        i_rs_addr = 5'd5;
        #1 check("comb_rs5", o_rs_data, 32'd5);

        // Zero register through every port, after loading the debug data with a nonzero value
        i_dbg_req = 1'b1; i_dbg_addr = 5'd31;
        tick();
        set_wr(1'b1, 5'd0, 32'h12345678);
        i_rs_addr = 5'd0; i_rt_addr = 5'd0; i_dbg_addr = 5'd0;
        #1 check("zero_rs_pre", o_rs_data, 32'd0);
        check("zero_rt_pre", o_rt_data, 32'd0);
        tick();
        set_wr(1'b0, 5'd0, 32'd0);
        i_dbg_req = 1'b0;
        #1 check("zero_rs_post", o_rs_data, 32'd0);
        check("zero_rt_post", o_rt_data, 32'd0);
        tick();

        // Debug stream: three back-to-back requests, then valid must drop
        set_wr(1'b1, 5'd1, 32'd10); tick();
        set_wr(1'b1, 5'd2, 32'd20); tick();
        set_wr(1'b1, 5'd3, 32'd30); tick();
        set_wr(1'b0, 5'd0, 32'd0);
        i_dbg_req = 1'b1;
        for (int a = 1; a <= 3; a++) begin
            i_dbg_addr = 5'(a);
            tick();
        end
        i_dbg_req = 1'b0;
        tick();
        tick();

        // Debug read with a same-cycle write to the requested index
        set_wr(1'b1, 5'd8, 32'h77);
        i_dbg_req = 1'b1; i_dbg_addr = 5'd8;
        tick();
        set_wr(1'b0, 5'd0, 32'd0);
        i_dbg_req = 1'b0;
        tick();

        // Reset wins over a write and a debug request on the same edge
        set_wr(1'b1, 5'd9, 32'h55);
        i_dbg_req = 1'b1; i_dbg_addr = 5'd9;
        i_reset = 1'b0;
        tick();
        i_reset = 1'b1;
        set_wr(1'b0, 5'd0, 32'd0);
        i_dbg_req = 1'b0;
        i_rs_addr = 5'd9;
        #1 check("rst_prio_r9", o_rs_data, 32'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
